matrix_result_streamer: RTL

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

---
 rtl/matrix_result_streamer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Captures one packed signed matrix (2x2 .. 5x5, 8-bit elements) on a start
//   pulse and streams its active elements row-major over a valid/ready
//   handshake, tagging each element with its flat index, row and column.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle capture request (honoured only when idle)
//   matrix_size  dimension code, n = matrix_size + 2
//   matrix_in    packed matrix, element k at bits [k*8+7 : k*8]
//   out_ready    downstream accepts the current element
//   out_valid    current element and tags are valid
//   out_data     current signed element
//   out_index    flat index k of the current element
//   out_row      row of the current element
//   out_col      column of the current element
//   out_last     current element is the final active element
//   busy         a captured matrix is being streamed
//   done         one-cycle pulse after the final transfer
module matrix_result_streamer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   matrix_size,
  input  logic [199:0] matrix_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic [4:0]   out_index,
  output logic [2:0]   out_row,
  output logic [2:0]   out_col,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int DATA_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]               state_p0;
  logic [199:0]             mat_p0;
  logic [1:0]               size_p0;
  logic [4:0]               k_p0;
  logic [2:0]               row_p0;
  logic [2:0]               col_p0;

  logic                     vld_p0;
  logic                     xfer;
  logic                     at_last;
  logic [2:0]               dim_m1;
  logic [4:0]               last_k;
  logic signed [DATA_W-1:0] cur_elem;

  // Dimension-derived limits come from the captured size, so a change on
  // matrix_size during streaming has no effect.
  always_comb begin
    dim_m1 = 3'd1 + {1'b0, size_p0};
    case (size_p0)
      2'b00:   last_k = 5'd3;
      2'b01:   last_k = 5'd8;
      2'b10:   last_k = 5'd15;
      default: last_k = 5'd24;
    endcase
  end

  assign vld_p0   = (state_p0 == SEND);
  assign xfer     = vld_p0 && out_ready;
  assign at_last  = (k_p0 == last_k);
  assign cur_elem = mat_p0[{k_p0, 3'b000} +: DATA_W];

  // Stage p0: capture register plus stream position. Row/column are tracked
  // incrementally alongside k so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      mat_p0   <= '0;
      size_p0  <= '0;
      k_p0     <= '0;
      row_p0   <= '0;
      col_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start) begin
            mat_p0   <= matrix_in;
            size_p0  <= matrix_size;
            k_p0     <= '0;
            row_p0   <= '0;
            col_p0   <= '0;
            state_p0 <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (at_last) begin
              state_p0 <= DONE;
            end else begin
              k_p0 <= k_p0 + 5'd1;
              if (col_p0 == dim_m1) begin
                col_p0 <= '0;
                row_p0 <= row_p0 + 3'd1;
              end else begin
                col_p0 <= col_p0 + 3'd1;
              end
            end
          end
        end
        DONE:    state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state so they are zero outside SEND and drop
  // immediately when reset is asserted.
  assign out_valid = vld_p0;
  assign out_data  = vld_p0 ? cur_elem : '0;
  assign out_index = vld_p0 ? k_p0 : '0;
  assign out_row   = vld_p0 ? row_p0 : '0;
  assign out_col   = vld_p0 ? col_p0 : '0;
  assign out_last  = vld_p0 && at_last;
  assign busy      = vld_p0;
  assign done      = (state_p0 == DONE);

endmodule
